// File: rtl/muldiv_unit_pkg.sv
// Shared types for the execute-stage multiply/divide unit: operation codes,
// PSW flag layout, step counts and sign helpers.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULU = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIVU = 2'd2,
        MD_DIV  = 2'd3
    } muldiv_operation_e;

    typedef struct packed {
        logic cy;
        logic v;
        logic s;
        logic z;
        logic ac;
        logic p;
    } flags_t;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_SETUP = 2'd1,
        MD_ITER  = 2'd2,
        MD_FIX   = 2'd3
    } md_state_e;

    localparam int MD_BYTE_STEPS = 8;
    localparam int MD_WORD_STEPS = 16;

    function automatic logic [15:0] md_abs16(input logic [15:0] x);
        return x[15] ? 16'(~x + 16'd1) : x;
    endfunction

    function automatic logic [31:0] md_neg32(input logic [31:0] x);
        return 32'(~x + 32'd1);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULU/MUL/DIVU/DIV unit: shift-add multiply, restoring divide.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the multiplier runs out of ones.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int BITS_PER_STEP = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  muldiv_operation_e operation,
    input  logic              wide,
    input  logic [15:0]       ta,
    input  logic [15:0]       td,
    input  logic [15:0]       tb,
    input  flags_t            flags_in,
    input  logic              execute,
    output logic              busy,
    output logic              done,
    output logic              div_error,
    output logic [15:0]       result_lo,
    output logic [15:0]       result_hi,
    output flags_t            flags
);

    md_state_e         state_q, state_d;
    muldiv_operation_e op_q, op_d;
    logic              wide_q, wide_d;
    logic [15:0]       ta_q, ta_d, td_q, td_d, tb_q, tb_d;
    flags_t            fin_q, fin_d;
    // acc holds the product for multiplies and {partial remainder, quotient} for divides;
    // mpl holds the multiplier or the divisor magnitude.
    logic [31:0]       acc_q, acc_d, mca_q, mca_d;
    logic [15:0]       mpl_q, mpl_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, ovf_q, ovf_d;
    logic              done_q, done_d, err_q, err_d;
    logic [15:0]       lo_q, lo_d, hi_q, hi_d;
    flags_t            fl_q, fl_d;

    logic              is_mul, is_sgn, a_neg, b_neg, dvd_neg, hi_ge;
    logic [15:0]       a_op, b_op, a_mag, b_mag, p_init, q_init;
    logic [31:0]       dvd, dvd_mag;
    logic [4:0]        n_steps;

    always_comb begin
        is_mul  = (op_q == MD_MULU) || (op_q == MD_MUL);
        is_sgn  = (op_q == MD_MUL) || (op_q == MD_DIV);
        a_op    = wide_q ? ta_q : {{8{is_sgn & ta_q[7]}}, ta_q[7:0]};
        b_op    = wide_q ? tb_q : {{8{is_sgn & tb_q[7]}}, tb_q[7:0]};
        a_neg   = is_sgn & a_op[15];
        b_neg   = is_sgn & b_op[15];
        a_mag   = a_neg ? md_abs16(a_op) : a_op;
        b_mag   = b_neg ? md_abs16(b_op) : b_op;
        dvd     = wide_q ? {td_q, ta_q} : {{16{is_sgn & ta_q[15]}}, ta_q};
        dvd_neg = is_sgn & dvd[31];
        dvd_mag = dvd_neg ? md_neg32(dvd) : dvd;
        // Byte dividends are left-aligned in the quotient half so both widths shift from bit 15.
        p_init  = wide_q ? dvd_mag[31:16] : {8'h00, dvd_mag[15:8]};
        q_init  = wide_q ? dvd_mag[15:0]  : {dvd_mag[7:0], 8'h00};
        hi_ge   = p_init >= b_mag;
        n_steps = 5'((wide_q ? MD_WORD_STEPS : MD_BYTE_STEPS) / BITS_PER_STEP);
    end

    logic [31:0] it_acc, it_mca;
    logic [15:0] it_mpl, it_p, it_q;
    logic [16:0] it_t;

    always_comb begin
        it_acc = acc_q;
        it_mca = mca_q;
        it_mpl = mpl_q;
        it_p   = acc_q[31:16];
        it_q   = acc_q[15:0];
        it_t   = '0;
        for (int i = 0; i < BITS_PER_STEP; i++) begin
            if (it_mpl[0]) it_acc = it_acc + it_mca;
            it_mca = it_mca << 1;
            it_mpl = it_mpl >> 1;
            it_t   = {it_p, it_q[15]};
            it_q   = {it_q[14:0], 1'b0};
            if (it_t >= {1'b0, mpl_q}) begin
                it_t    = it_t - {1'b0, mpl_q};
                it_q[0] = 1'b1;
            end
            it_p = it_t[15:0];
        end
    end

    logic [31:0] prod;
    logic        sig, quo_bad;
    logic [15:0] quo_mag, rem_mag, quo, rem;
    logic [16:0] quo_lim;

    always_comb begin
        prod    = neg_res_q ? md_neg32(acc_q) : acc_q;
        if (wide_q) sig = is_sgn ? (prod[31:16] != {16{prod[15]}}) : (prod[31:16] != 16'h0);
        else        sig = is_sgn ? (prod[15:8] != {8{prod[7]}})    : (prod[15:8] != 8'h00);
        quo_mag = wide_q ? acc_q[15:0]  : {8'h00, acc_q[7:0]};
        rem_mag = wide_q ? acc_q[31:16] : {8'h00, acc_q[23:16]};
        quo     = neg_res_q ? 16'(~quo_mag + 16'd1) : quo_mag;
        rem     = neg_rem_q ? 16'(~rem_mag + 16'd1) : rem_mag;
        // A negative quotient may reach one step further than a positive one.
        quo_lim = wide_q ? (neg_res_q ? 17'd32768 : 17'd32767) : (neg_res_q ? 17'd128 : 17'd127);
        quo_bad = is_sgn & (ovf_q | ({1'b0, quo_mag} > quo_lim));
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wide_d    = wide_q;
        ta_d      = ta_q;
        td_d      = td_q;
        tb_d      = tb_q;
        fin_d     = fin_q;
        acc_d     = acc_q;
        mca_d     = mca_q;
        mpl_d     = mpl_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        lo_d      = lo_q;
        hi_d      = hi_q;
        fl_d      = fl_q;
        case (state_q)
            MD_IDLE: begin
                if (execute) begin
                    op_d    = operation;
                    wide_d  = wide;
                    ta_d    = ta;
                    td_d    = td;
                    tb_d    = tb;
                    fin_d   = flags_in;
                    state_d = MD_SETUP;
                end
            end
            MD_SETUP: begin
                cnt_d     = n_steps;
                neg_rem_d = dvd_neg;
                ovf_d     = hi_ge;
                if (is_mul) begin
                    acc_d     = '0;
                    mca_d     = {16'h0000, a_mag};
                    mpl_d     = b_mag;
                    neg_res_d = a_neg ^ b_neg;
                    state_d   = MD_ITER;
`ifdef MULDIV_EARLY_OUT_EN
                    if (b_mag == 16'h0000) state_d = MD_FIX;
`endif
                end else if ((b_mag == 16'h0000) || (!is_sgn && hi_ge)) begin
                    err_d   = 1'b1;
                    state_d = MD_IDLE;
                end else begin
                    acc_d     = {p_init, q_init};
                    mpl_d     = b_mag;
                    neg_res_d = dvd_neg ^ b_neg;
                    state_d   = MD_ITER;
                end
            end
            MD_ITER: begin
                cnt_d = cnt_q - 5'd1;
                if (is_mul) begin
                    acc_d = it_acc;
                    mca_d = it_mca;
                    mpl_d = it_mpl;
                end else begin
                    acc_d = {it_p, it_q};
                end
                if (cnt_q == 5'd1) state_d = MD_FIX;
`ifdef MULDIV_EARLY_OUT_EN
                if (is_mul && (it_mpl == 16'h0000)) state_d = MD_FIX;
`endif
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                if (is_mul) begin
                    lo_d    = prod[15:0];
                    hi_d    = wide_q ? prod[31:16] : 16'h0000;
                    fl_d    = fin_q;
                    fl_d.cy = sig;
                    fl_d.v  = sig;
                    done_d  = 1'b1;
                end else if (quo_bad) begin
                    err_d = 1'b1;
                end else begin
                    lo_d   = wide_q ? quo : {rem[7:0], quo[7:0]};
                    hi_d   = wide_q ? rem : 16'h0000;
                    fl_d   = fin_q;
                    done_d = 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= MD_IDLE;
            op_q      <= MD_MULU;
            wide_q    <= 1'b0;
            ta_q      <= '0;
            td_q      <= '0;
            tb_q      <= '0;
            fin_q     <= '0;
            acc_q     <= '0;
            mca_q     <= '0;
            mpl_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            fl_q      <= '0;
        end else if (ce) begin
            state_q   <= state_d;
            op_q      <= op_d;
            wide_q    <= wide_d;
            ta_q      <= ta_d;
            td_q      <= td_d;
            tb_q      <= tb_d;
            fin_q     <= fin_d;
            acc_q     <= acc_d;
            mca_q     <= mca_d;
            mpl_q     <= mpl_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            err_q     <= err_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            fl_q      <= fl_d;
        end
    end

    assign busy      = execute | (state_q != MD_IDLE);
    assign done      = done_q;
    assign div_error = err_q;
    assign result_lo = lo_q;
    assign result_hi = hi_q;
    assign flags     = fl_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random operations checked against a plain-arithmetic model of the unit.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n, ce, wide, execute;
    muldiv_operation_e operation;
    logic [15:0]       ta, td, tb;
    flags_t            flags_in, flags;
    logic              busy, done, div_error;
    logic [15:0]       result_lo, result_hi;

    int                nvec = 0;
    int                nerr = 0;
    logic [15:0]       prev_lo, prev_hi;
    flags_t            prev_fl;

    muldiv_unit dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .operation(operation), .wide(wide),
        .ta(ta), .td(td), .tb(tb), .flags_in(flags_in), .execute(execute),
        .busy(busy), .done(done), .div_error(div_error),
        .result_lo(result_lo), .result_hi(result_hi), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: results straight from integer arithmetic and the error rules.
    function automatic void model(input muldiv_operation_e o, input logic w,
                                  input logic [15:0] a, input logic [15:0] d, input logic [15:0] b,
                                  output logic err, output logic setup_err,
                                  output logic [15:0] lo, output logic [15:0] hi, output logic sig);
        longint x, y, q, r, p;
        err = 1'b0; setup_err = 1'b0; lo = '0; hi = '0; sig = 1'b0;
        x = 0; y = 0; q = 0; r = 0; p = 0;
        case (o)
            MD_MULU: begin
                x = w ? longint'(a) : longint'(a[7:0]);
                y = w ? longint'(b) : longint'(b[7:0]);
                p = x * y;
                lo = p[15:0];
                hi = w ? p[31:16] : 16'h0;
                sig = w ? (p > 65535) : (p > 255);
            end
            MD_MUL: begin
                x = w ? longint'($signed(a)) : longint'($signed(a[7:0]));
                y = w ? longint'($signed(b)) : longint'($signed(b[7:0]));
                p = x * y;
                lo = p[15:0];
                hi = w ? p[31:16] : 16'h0;
                sig = w ? (p < -32768 || p > 32767) : (p < -128 || p > 127);
            end
            MD_DIVU: begin
                x = w ? longint'({d, a}) : longint'(a);
                y = w ? longint'(b) : longint'(b[7:0]);
                if (y == 0) setup_err = 1'b1;
                else begin
                    q = x / y; r = x % y;
                    if (q > (w ? 65535 : 255)) setup_err = 1'b1;
                    else begin
                        lo = w ? q[15:0] : {r[7:0], q[7:0]};
                        hi = w ? r[15:0] : 16'h0;
                    end
                end
                err = setup_err;
            end
            default: begin
                x = w ? longint'($signed({d, a})) : longint'($signed(a));
                y = w ? longint'($signed(b)) : longint'($signed(b[7:0]));
                if (y == 0) setup_err = 1'b1;
                else begin
                    q = x / y; r = x % y;
                    if (q < (w ? -32768 : -128) || q > (w ? 32767 : 127)) err = 1'b1;
                    else begin
                        lo = w ? q[15:0] : {r[7:0], q[7:0]};
                        hi = w ? r[15:0] : 16'h0;
                    end
                end
                err = err | setup_err;
            end
        endcase
    endfunction

    task automatic run(input muldiv_operation_e o, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] b, input int ce_gap, input logic poke);
        logic        e_err, e_setup, e_sig;
        logic [15:0] e_lo, e_hi;
        flags_t      fl, e_fl;
        int          lat, cyc;
        model(o, w, a, d, b, e_err, e_setup, e_lo, e_hi, e_sig);
        fl = flags_t'(6'($urandom));
        e_fl = fl;
        if (o == MD_MULU || o == MD_MUL) begin
            e_fl.cy = e_sig;
            e_fl.v  = e_sig;
        end
        lat = e_setup ? 2 : ((w ? 19 : 11) + ce_gap);
        if (e_err) begin
            e_lo = prev_lo; e_hi = prev_hi; e_fl = prev_fl;
        end
        @(negedge clk);
        operation = o; wide = w; ta = a; td = d; tb = b; flags_in = fl; execute = 1'b1;
        @(posedge clk); #1;
        execute = 1'b0;
        cyc = 1;
        chk("busy_start", 32'(busy), 32'd1);
        while (!(done || div_error) && cyc < 100) begin
            if (poke && cyc == 4) begin
                execute = 1'b1; operation = MD_MULU; ta = ~a; tb = b + 16'd1;
            end else begin
                execute = 1'b0;
            end
            ce = (cyc >= 3 && cyc < 3 + ce_gap) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        execute = 1'b0;
        ce = 1'b1;
        chk("done", 32'(done), 32'(!e_err));
        chk("div_error", 32'(div_error), 32'(e_err));
        chk("latency", 32'(cyc), 32'(lat));
        chk("result_lo", 32'(result_lo), 32'(e_lo));
        chk("result_hi", 32'(result_hi), 32'(e_hi));
        chk("flags", 32'(flags), 32'(e_fl));
        chk("busy_end", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("pulse_clear", 32'({done, div_error}), 32'd0);
        prev_lo = e_lo; prev_hi = e_hi; prev_fl = e_fl;
    endtask

    initial begin
        muldiv_operation_e o;
        logic              w;
        logic [15:0]       a, d, b;
        reset_n = 1'b0; ce = 1'b1; execute = 1'b0; operation = MD_MULU; wide = 1'b0;
        ta = '0; td = '0; tb = '0; flags_in = '0;
        prev_lo = '0; prev_hi = '0; prev_fl = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 32'({done, div_error, busy, result_lo, result_hi}), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        @(negedge clk) reset_n = 1'b1;

        run(MD_MULU, 1'b0, 16'h00FF, 16'h0000, 16'h00FF, 0, 1'b0);
        run(MD_MUL,  1'b1, 16'hFFFF, 16'h0000, 16'h0002, 0, 1'b0);
        run(MD_DIVU, 1'b1, 16'h0000, 16'h0001, 16'h0003, 0, 1'b0);
        run(MD_DIV,  1'b0, 16'hFFF9, 16'h0000, 16'h0002, 0, 1'b0);
        run(MD_DIVU, 1'b1, 16'h1234, 16'h0000, 16'h0000, 0, 1'b0);
        run(MD_DIVU, 1'b0, 16'h0400, 16'h0000, 16'h0002, 0, 1'b0);
        run(MD_DIV,  1'b0, 16'h0100, 16'h0000, 16'h0002, 0, 1'b0);
        run(MD_DIV,  1'b0, 16'h0123, 16'h0000, 16'hFF00, 0, 1'b0);
        run(MD_MUL,  1'b0, 16'h0080, 16'h0000, 16'h00FF, 0, 1'b0);
        run(MD_DIV,  1'b1, 16'h0000, 16'h8000, 16'hFFFF, 0, 1'b0);
        run(MD_DIV,  1'b1, 16'hFFF9, 16'hFFFF, 16'h0002, 0, 1'b0);
        run(MD_DIV,  1'b0, 16'hFF80, 16'h0000, 16'h00FF, 0, 1'b0);
        run(MD_MULU, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 1'b0);
        run(MD_MULU, 1'b0, 16'h0012, 16'h0000, 16'h0034, 5, 1'b0);
        run(MD_DIVU, 1'b1, 16'h5678, 16'h0012, 16'h1234, 0, 1'b1);

        // Asynchronous reset while iterating
        @(negedge clk);
        operation = MD_MULU; wide = 1'b1; ta = 16'h1234; tb = 16'h5678; execute = 1'b1;
        @(posedge clk); #1;
        execute = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midop_reset_out", 32'({done, div_error, busy, result_lo, result_hi}), 32'd0);
        chk("midop_reset_flags", 32'(flags), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        prev_lo = '0; prev_hi = '0; prev_fl = '0;
        run(MD_MUL, 1'b1, 16'h8000, 16'h0000, 16'h8000, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            o = muldiv_operation_e'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            a = 16'($urandom); d = 16'($urandom); b = 16'($urandom);
            if (o == MD_DIVU && $urandom_range(0, 3) != 0) begin
                if (w && b != 16'h0) d = d % b;
                else if (!w && b[7:0] != 8'h0) a[15:8] = a[15:8] % b[7:0];
            end
            if (o == MD_DIV && $urandom_range(0, 1) != 0) begin
                d = {16{a[15]}};
                a[15:8] = {8{a[7]}};
            end
            run(o, w, a, d, b, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
